// File: rtl/uart_video_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_video_cmd_decoder
//
// Purpose:
//   Parses ASCII command lines arriving from the UART receiver and drives the
//   pattern/colour selection of the video test-pattern stage.
//     "P<h>"      + CR/LF : select pattern <h> (one hex digit, either case)
//     "C<r><g><b>"+ CR/LF : select colour, each component an octal digit 0-7
//   Decoded values land in shadow registers. They are copied to the video
//   outputs only while i_vblank is high, so a change never tears a frame.
//   Every non-empty line is answered with 'K' (accepted) or 'E' (rejected)
//   through a one-entry response buffer toward the UART transmitter.
//
// Ports:
//   i_clk        system / pixel clock
//   i_reset      asynchronous, active-high reset
//   i_rx_byte    received byte, qualified by i_rx_valid
//   i_rx_valid   one-cycle strobe per received byte
//   i_vblank     vertical blanking indicator from the sync generator
//   o_pattern    committed test-pattern select
//   o_color      committed foreground colour {R[2:0],G[2:0],B[2:0]}
//   o_cmd_error  one-cycle pulse after a line that ended in error
//   o_tx_byte    response byte ('K' or 'E')
//   o_tx_valid   response available, held until accepted
//   i_tx_ready   downstream accepts o_tx_byte when o_tx_valid & i_tx_ready
// ---------------------------------------------------------------------------
module uart_video_cmd_decoder #(
    parameter logic [3:0] RESET_PATTERN = 4'h0,
    parameter logic [8:0] RESET_COLOR   = 9'h1FF,
    parameter bit         ACK_ENABLE    = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    input  logic       i_vblank,
    output logic [3:0] o_pattern,
    output logic [8:0] o_color,
    output logic       o_cmd_error,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_valid,
    input  logic       i_tx_ready
);

    localparam logic [7:0] ACK_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] ACK_ERR = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_ARG,
        S_C_ARG,
        S_WAIT_TERM,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  temp_q, temp_d;        // argument being assembled
    logic [1:0]  cnt_q, cnt_d;          // colour digits received so far
    logic        is_col_q, is_col_d;    // current line is a colour command
    logic [3:0]  pat_sh_q, pat_sh_d;
    logic [8:0]  col_sh_q, col_sh_d;
    logic        pending_q, pending_d;
    logic [3:0]  pattern_q, pattern_d;
    logic [8:0]  color_q, color_d;
    logic        err_q, err_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;

    // Byte classification
    logic        is_term;
    logic        is_hex;
    logic        is_oct;
    logic        is_p_cmd;
    logic        is_c_cmd;
    logic [7:0]  hex_off;
    logic [3:0]  hex_val;
    logic        success;
    logic        error;

    always_comb begin
        is_term  = (i_rx_byte == 8'h0D) || (i_rx_byte == 8'h0A);
        is_p_cmd = (i_rx_byte == 8'h50) || (i_rx_byte == 8'h70);
        is_c_cmd = (i_rx_byte == 8'h43) || (i_rx_byte == 8'h63);
        is_oct   = (i_rx_byte >= 8'h30) && (i_rx_byte <= 8'h37);
        is_hex   = 1'b1;
        hex_off  = i_rx_byte - 8'h30;
        if (i_rx_byte >= 8'h30 && i_rx_byte <= 8'h39) begin
            hex_off = i_rx_byte - 8'h30;
        end else if (i_rx_byte >= 8'h41 && i_rx_byte <= 8'h46) begin
            hex_off = i_rx_byte - 8'h37;
        end else if (i_rx_byte >= 8'h61 && i_rx_byte <= 8'h66) begin
            hex_off = i_rx_byte - 8'h57;
        end else begin
            is_hex = 1'b0;
        end
        hex_val = hex_off[3:0];
    end

    // Line parser: next state and argument assembly
    always_comb begin
        state_d  = state_q;
        temp_d   = temp_q;
        cnt_d    = cnt_q;
        is_col_d = is_col_q;
        success  = 1'b0;
        error    = 1'b0;
        if (i_rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_p_cmd) begin
                        state_d  = S_P_ARG;
                        is_col_d = 1'b0;
                    end else if (is_c_cmd) begin
                        state_d  = S_C_ARG;
                        is_col_d = 1'b1;
                        cnt_d    = 2'd0;
                    end else if (!is_term) begin
                        // Empty lines and the LF of a CRLF pair are silent.
                        state_d = S_DISCARD;
                    end
                end
                S_P_ARG: begin
                    if (is_hex) begin
                        temp_d  = {5'd0, hex_val};
                        state_d = S_WAIT_TERM;
                    end else if (is_term) begin
                        error   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_C_ARG: begin
                    if (is_oct) begin
                        // First digit is red, placed in the top field.
                        unique case (cnt_q)
                            2'd0:    temp_d[8:6] = i_rx_byte[2:0];
                            2'd1:    temp_d[5:3] = i_rx_byte[2:0];
                            default: temp_d[2:0] = i_rx_byte[2:0];
                        endcase
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd2) begin
                            state_d = S_WAIT_TERM;
                        end
                    end else if (is_term) begin
                        error   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_WAIT_TERM: begin
                    if (is_term) begin
                        success = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_term) begin
                        error   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Shadows, vblank commit and response buffer
    logic commit;
    logic accept;
    logic respond;

    always_comb begin
        pat_sh_d = pat_sh_q;
        col_sh_d = col_sh_q;
        if (success) begin
            if (is_col_q) begin
                col_sh_d = temp_q;
            end else begin
                pat_sh_d = temp_q[3:0];
            end
        end

        // Commit reads the shadows before this cycle's update; a success in
        // the same cycle keeps pending set so it lands on the next vblank.
        commit    = pending_q & i_vblank;
        pending_d = success | (pending_q & ~i_vblank);
        pattern_d = commit ? pat_sh_q : pattern_q;
        color_d   = commit ? col_sh_q : color_q;

        err_d = error;

        accept     = tx_valid_q & i_tx_ready;
        respond    = (success | error) & ACK_ENABLE;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        if (respond && (!tx_valid_q || accept)) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = success ? ACK_OK : ACK_ERR;
        end else if (accept) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            pat_sh_q   <= RESET_PATTERN;
            col_sh_q   <= RESET_COLOR;
            pending_q  <= 1'b0;
            pattern_q  <= RESET_PATTERN;
            color_q    <= RESET_COLOR;
            err_q      <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_sh_q   <= pat_sh_d;
            col_sh_q   <= col_sh_d;
            pending_q  <= pending_d;
            pattern_q  <= pattern_d;
            color_q    <= color_d;
            err_q      <= err_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Argument scratch is only read after being written on the same line.
    always_ff @(posedge i_clk) begin
        temp_q   <= temp_d;
        cnt_q    <= cnt_d;
        is_col_q <= is_col_d;
    end

    assign o_pattern   = pattern_q;
    assign o_color     = color_q;
    assign o_cmd_error = err_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_uart_video_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_video_cmd_decoder
//
// Purpose:
//   Scoreboard bench for uart_video_cmd_decoder. Stimulus tasks feed whole
//   command lines; a line-level reference model classifies each completed
//   line and queues the expected response byte and error pulse. A monitor
//   process pops and compares every accepted response byte.
// ---------------------------------------------------------------------------
module tb_uart_video_cmd_decoder;

    typedef logic [7:0] u8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       vblank;
    logic [3:0] pattern;
    logic [8:0] color;
    logic       cmd_error;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    always #20 clk = ~clk;

    uart_video_cmd_decoder dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_byte   (rx_byte),
        .i_rx_valid  (rx_valid),
        .i_vblank    (vblank),
        .o_pattern   (pattern),
        .o_color     (color),
        .o_cmd_error (cmd_error),
        .o_tx_byte   (tx_byte),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state (line level)
    u8          exp_q[$];
    u8          linebuf[$];
    int         exp_err  = 0;
    int         got_err  = 0;
    int         accepts  = 0;
    logic [3:0] m_pat, m_pat_sh;
    logic [8:0] m_col, m_col_sh;
    bit         m_pend;
    bit         tx_hold  = 1'b0;
    bit         m_full   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count error pulses, compare each accepted response
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_error) got_err++;
            if (tx_valid && tx_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h expected=none", tx_byte);
                end else begin
                    check("tx_byte", int'(tx_byte), int'(exp_q.pop_front()));
                end
            end
        end
    end

    function automatic bit is_hex(input u8 b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic logic [3:0] hexval(input u8 b);
        if (b >= "0" && b <= "9") return 4'(b - "0");
        if (b >= "A" && b <= "F") return 4'(b - "A" + 10);
        return 4'(b - "a" + 10);
    endfunction

    function automatic bit is_oct(input u8 b);
        return b >= "0" && b <= "7";
    endfunction

    // 1 = pattern ok, 2 = colour ok, 3 = error
    function automatic int classify(input u8 ln[$], output logic [8:0] val);
        val = '0;
        if (ln.size() == 2 && (ln[0] == "P" || ln[0] == "p") && is_hex(ln[1])) begin
            val = {5'd0, hexval(ln[1])};
            return 1;
        end
        if (ln.size() == 4 && (ln[0] == "C" || ln[0] == "c") &&
            is_oct(ln[1]) && is_oct(ln[2]) && is_oct(ln[3])) begin
            val = {ln[1][2:0], ln[2][2:0], ln[3][2:0]};
            return 2;
        end
        return 3;
    endfunction

    task automatic push_resp(input u8 r);
        if (!tx_hold) begin
            exp_q.push_back(r);
        end else if (!m_full) begin
            exp_q.push_back(r);
            m_full = 1'b1;
        end
    endtask

    task automatic model_byte(input u8 b);
        int k;
        logic [8:0] v;
        if (b == 8'h0D || b == 8'h0A) begin
            if (linebuf.size() != 0) begin
                k = classify(linebuf, v);
                if (k == 3) begin
                    exp_err++;
                    push_resp("E");
                end else begin
                    push_resp("K");
                    if (k == 1) m_pat_sh = v[3:0];
                    else        m_col_sh = v;
                    m_pend = 1'b1;
                end
                linebuf.delete();
            end
        end else begin
            linebuf.push_back(b);
        end
    endtask

    task automatic model_reset();
        linebuf.delete();
        exp_q.delete();
        m_pat = 4'h0; m_pat_sh = 4'h0;
        m_col = 9'h1FF; m_col_sh = 9'h1FF;
        m_pend = 1'b0;
        m_full = 1'b0;
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input u8 b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(u8'(s[i]));
        tick(1);
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_pattern"}, int'(pattern), int'(m_pat));
        check({tag, "_color"}, int'(color), int'(m_col));
    endtask

    task automatic do_vblank(input int n, input string tag);
        vblank = 1'b1;
        tick(n);
        vblank = 1'b0;
        if (m_pend) begin
            m_pat  = m_pat_sh;
            m_col  = m_col_sh;
            m_pend = 1'b0;
        end
        check_outs(tag);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        check({tag, "_resp_left"}, exp_q.size(), 0);
        check({tag, "_err_count"}, got_err, exp_err);
    endtask

    initial begin
        string hx, gs;
        int a0, r, len;
        u8 ln[$];

        hx = "0123456789ABCDEFabcdef";
        gs = "PpCc0123789AFGZx !";
        rst = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; vblank = 1'b0; tx_ready = 1'b1;
        model_reset();
        tick(3);
        check("rst_pattern", int'(pattern), 0);
        check("rst_color", int'(color), 9'h1FF);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_byte", int'(tx_byte), 0);
        check("rst_cmd_error", int'(cmd_error), 0);
        rst = 1'b0;
        tick(2);

        // Pattern change held off until blanking
        send_line("P5\r");
        tick(4);
        check("p5_pre_vblank", int'(pattern), 0);
        do_vblank(1, "p5_vblank");
        check("p5_committed", int'(pattern), 5);
        drain("p5");

        // Short colour line errors, full one succeeds
        send_line("C7\r");
        send_line("C707\r");
        drain("color");
        check_outs("color_pre_vblank");
        do_vblank(1, "color_vblank");
        check("color_value", int'(color), 9'b111_000_111);

        // CRLF lines, last value wins
        send_line("PA\r\n");
        send_line("P3\r\n");
        send_line("PC\r\n");
        drain("crlf");
        check_outs("crlf_pre_vblank");
        do_vblank(2, "crlf_vblank");
        check("crlf_pattern", int'(pattern), 4'hC);

        // Malformed lines leave outputs untouched
        send_line("X12\r");
        send_line("c8\r");
        send_line("P5Z\r");
        drain("errors");
        do_vblank(1, "errors_vblank");

        // Response buffer full: second response dropped
        tx_ready = 1'b0;
        tx_hold  = 1'b1;
        send_line("P1\r");
        send_line("P2\r");
        tick(3);
        check("hold_tx_valid", int'(tx_valid), 1);
        check("hold_tx_byte", int'(tx_byte), 8'h4B);
        a0 = accepts;
        tx_ready = 1'b1;
        tx_hold  = 1'b0;
        m_full   = 1'b0;
        tick(5);
        check("hold_accepts", accepts - a0, 1);
        check("hold_tx_valid_after", int'(tx_valid), 0);
        drain("hold");
        do_vblank(1, "hold_vblank");

        // Success and commit on the same cycle
        send_line("P3\r");
        send_byte("P");
        send_byte("7");
        vblank = 1'b1;
        send_byte(8'h0D);
        check("same_cycle_old_shadow", int'(pattern), 3);
        tick(1);
        vblank = 1'b0;
        check("same_cycle_next_commit", int'(pattern), 7);
        m_pat = m_pat_sh; m_col = m_col_sh; m_pend = 1'b0;
        drain("same_cycle");

        // Reset mid-line
        send_byte("C");
        send_byte("1");
        send_byte("2");
        rst = 1'b1;
        tick(1);
        model_reset();
        check_outs("midreset");
        check("midreset_tx_valid", int'(tx_valid), 0);
        rst = 1'b0;
        tick(1);
        send_line("3\r");
        drain("midreset");
        do_vblank(1, "midreset_vblank");

        // Randomised lines
        for (int n = 0; n < 60; n++) begin
            ln.delete();
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                ln.push_back($urandom_range(0, 1) ? "P" : "p");
                ln.push_back(u8'(hx[$urandom_range(0, 21)]));
            end else if (r <= 6) begin
                ln.push_back($urandom_range(0, 1) ? "C" : "c");
                for (int d = 0; d < 3; d++) ln.push_back(u8'("0" + $urandom_range(0, 7)));
            end else begin
                len = $urandom_range(1, 5);
                for (int d = 0; d < len; d++) ln.push_back(u8'(gs[$urandom_range(0, gs.len() - 1)]));
            end
            r = $urandom_range(0, 2);
            if (r != 1) ln.push_back(8'h0D);
            if (r != 0) ln.push_back(8'h0A);
            foreach (ln[i]) begin
                send_byte(ln[i]);
                tick($urandom_range(0, 2));
            end
            if (n % 5 == 4) begin
                check_outs("rand_pre_vblank");
                do_vblank($urandom_range(1, 3), "rand_vblank");
            end
        end
        drain("rand");
        do_vblank(1, "final_vblank");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
